// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone master bridge: response status codes,
// bridge FSM state encoding and the status field width.
package wb_pkg;

    localparam int WB_STATUS_W = 2;

    typedef enum logic [WB_STATUS_W-1:0] {
        WB_STATUS_OK              = 2'd0,
        WB_STATUS_ERR             = 2'd1,
        WB_STATUS_RETRY_EXHAUSTED = 2'd2,
        WB_STATUS_TIMEOUT         = 2'd3
    } wb_status_e;

    typedef enum logic [1:0] {
        WB_MS_IDLE  = 2'd0,
        WB_MS_CYCLE = 2'd1,
        WB_MS_RETRY = 2'd2,
        WB_MS_RESP  = 2'd3
    } wb_master_state_e;

endpackage

// File: rtl/wb_master_watchdog.sv
// Per-attempt watchdog for the Wishbone master bridge. Counts cycles while
// 'run' is high and flags 'expired' during the TIMEOUT_CYCLES-th cycle of a run.
// Dropping 'run' restarts the count. Only compiled when WB_MASTER_TIMEOUT_EN
// is defined, since the bridge instantiates it only in that build.
`ifdef WB_MASTER_TIMEOUT_EN
module wb_master_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_reg;

    // Count cycles of the current run, saturating at the limit.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt_reg <= '0;
        end else if (cnt_reg != LAST) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign expired = run && (cnt_reg == LAST);

endmodule
`endif

// File: rtl/wb_master_bridge.sv
// Single-outstanding Wishbone B4 classic master. Accepts one command on a
// valid/ready stream, runs one bus cycle (re-issuing on rty up to MAX_RETRY
// times) and returns one status/data response.
// Optional watchdog: define WB_MASTER_TIMEOUT_EN to abort silent cycles after
// TIMEOUT_CYCLES with status TIMEOUT.
module wb_master_bridge
    import wb_pkg::*;
#(
    parameter int WB_ADDRESS_W   = 8,
    parameter int WB_WORD_W      = 8,
    parameter int WB_SEL_W       = 1,
    parameter int MAX_RETRY      = 3,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int WB_DATA_W     = WB_WORD_W * WB_SEL_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [WB_ADDRESS_W-1:0] req_adr,
    input  logic                    req_we,
    input  logic [WB_DATA_W-1:0]    req_dat,
    input  logic [WB_SEL_W-1:0]     req_sel,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WB_DATA_W-1:0]    rsp_dat,
    output logic [WB_STATUS_W-1:0]  rsp_status,
    output logic [WB_ADDRESS_W-1:0] wb_adr,
    output logic [WB_DATA_W-1:0]    wb_dat_o,
    input  logic [WB_DATA_W-1:0]    wb_dat_i,
    output logic [WB_SEL_W-1:0]     wb_sel,
    output logic                    wb_we,
    output logic                    wb_cyc,
    output logic                    wb_stb,
    input  logic                    wb_ack,
    input  logic                    wb_err,
    input  logic                    wb_rty
);

    localparam logic [1:0] ST_IDLE  = WB_MS_IDLE;
    localparam logic [1:0] ST_CYCLE = WB_MS_CYCLE;
    localparam logic [1:0] ST_RETRY = WB_MS_RETRY;
    localparam logic [1:0] ST_RESP  = WB_MS_RESP;

    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    logic [1:0]              state_reg, state_next;
    logic [RETRY_W-1:0]      retry_cnt_reg;
    logic                    cmd_we_reg;
    logic                    cyc_reg;
    logic                    we_bus_reg;
    logic [WB_ADDRESS_W-1:0] adr_reg;
    logic [WB_DATA_W-1:0]    dat_o_reg;
    logic [WB_SEL_W-1:0]     sel_reg;
    logic                    rsp_valid_reg;
    logic [WB_DATA_W-1:0]    rsp_dat_reg;
    logic [WB_STATUS_W-1:0]  rsp_status_reg;

    logic                    timeout_expired;
    logic                    done;
    logic                    retry_go;
    wb_status_e              done_status;
    logic [WB_DATA_W-1:0]    done_dat;

`ifdef WB_MASTER_TIMEOUT_EN
    wb_master_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .run     (state_reg == ST_CYCLE),
        .expired (timeout_expired)
    );
`else
    // No watchdog in this build: the comparison is constant false, so CYCLE
    // waits for a slave termination indefinitely.
    assign timeout_expired = (TIMEOUT_CYCLES < 0);
`endif

    // Resolve the bus termination for this edge: err > rty > ack > timeout.
    always_comb begin
        done        = 1'b0;
        retry_go    = 1'b0;
        done_status = WB_STATUS_OK;
        done_dat    = '0;
        if (state_reg == ST_CYCLE) begin
            if (wb_err) begin
                done        = 1'b1;
                done_status = WB_STATUS_ERR;
            end else if (wb_rty) begin
                if (retry_cnt_reg < RETRY_LIMIT) begin
                    retry_go = 1'b1;
                end else begin
                    done        = 1'b1;
                    done_status = WB_STATUS_RETRY_EXHAUSTED;
                end
            end else if (wb_ack) begin
                done     = 1'b1;
                done_dat = cmd_we_reg ? '0 : wb_dat_i;
            end else if (timeout_expired) begin
                done        = 1'b1;
                done_status = WB_STATUS_TIMEOUT;
            end
        end
    end

    // FSM next-state selection.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (req_valid) state_next = ST_CYCLE;
            ST_CYCLE: begin
                if (done) begin
                    state_next = ST_RESP;
                end else if (retry_go) begin
                    state_next = ST_RETRY;
                end
            end
            ST_RETRY: state_next = ST_CYCLE;
            ST_RESP:  if (rsp_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State, latched command, registered bus outputs and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            retry_cnt_reg  <= '0;
            cmd_we_reg     <= 1'b0;
            cyc_reg        <= 1'b0;
            we_bus_reg     <= 1'b0;
            adr_reg        <= '0;
            dat_o_reg      <= '0;
            sel_reg        <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_dat_reg    <= '0;
            rsp_status_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        adr_reg       <= req_adr;
                        dat_o_reg     <= req_dat;
                        sel_reg       <= req_sel;
                        cmd_we_reg    <= req_we;
                        we_bus_reg    <= req_we;
                        cyc_reg       <= 1'b1;
                        retry_cnt_reg <= '0;
                    end
                end
                ST_CYCLE: begin
                    if (done) begin
                        cyc_reg        <= 1'b0;
                        we_bus_reg     <= 1'b0;
                        rsp_valid_reg  <= 1'b1;
                        rsp_status_reg <= done_status;
                        rsp_dat_reg    <= done_dat;
                    end else if (retry_go) begin
                        cyc_reg       <= 1'b0;
                        we_bus_reg    <= 1'b0;
                        retry_cnt_reg <= retry_cnt_reg + RETRY_W'(1);
                    end
                end
                ST_RETRY: begin
                    // One idle cycle done; re-issue the same command.
                    cyc_reg    <= 1'b1;
                    we_bus_reg <= cmd_we_reg;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (state_reg == ST_IDLE);
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_dat    = rsp_dat_reg;
    assign rsp_status = rsp_status_reg;
    assign wb_adr     = adr_reg;
    assign wb_dat_o   = dat_o_reg;
    assign wb_sel     = sel_reg;
    assign wb_we      = we_bus_reg;
    assign wb_cyc     = cyc_reg;
    assign wb_stb     = cyc_reg;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed self-checking bench for wb_master_bridge (8-bit address/data,
// MAX_RETRY=3, TIMEOUT_CYCLES=8). Inputs change and outputs are sampled on
// the falling clock edge. Define WB_MASTER_TIMEOUT_EN to cover the watchdog.
module tb_wb_master_bridge;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_adr;
    logic       req_we;
    logic [7:0] req_dat;
    logic [0:0] req_sel;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_dat;
    logic [1:0] rsp_status;
    logic [7:0] wb_adr;
    logic [7:0] wb_dat_o;
    logic [7:0] wb_dat_i;
    logic [0:0] wb_sel;
    logic       wb_we;
    logic       wb_cyc;
    logic       wb_stb;
    logic       wb_ack;
    logic       wb_err;
    logic       wb_rty;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    wb_master_bridge #(
        .WB_ADDRESS_W   (8),
        .WB_WORD_W      (8),
        .WB_SEL_W       (1),
        .MAX_RETRY      (3),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_adr    (req_adr),
        .req_we     (req_we),
        .req_dat    (req_dat),
        .req_sel    (req_sel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_dat    (rsp_dat),
        .rsp_status (rsp_status),
        .wb_adr     (wb_adr),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_sel     (wb_sel),
        .wb_we      (wb_we),
        .wb_cyc     (wb_cyc),
        .wb_stb     (wb_stb),
        .wb_ack     (wb_ack),
        .wb_err     (wb_err),
        .wb_rty     (wb_rty)
    );

    // Present one command while the bridge is idle; returns at the falling
    // edge of the first bus cycle (cycle N+1 after acceptance edge N).
    task automatic issue(input logic [7:0] adr, input logic we, input logic [7:0] dat);
        @(negedge clk);
        req_adr   = adr;
        req_we    = we;
        req_dat   = dat;
        req_sel   = 1'b1;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Consume a pending response with a one-cycle rsp_ready pulse.
    task automatic consume();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({req_ready, rsp_valid, rsp_dat, rsp_status, wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o, wb_sel}
            !== {1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0})
            $display("FAIL reset_values got rdy=%b vld=%b dat=%h st=%0d cyc=%b stb=%b we=%b adr=%h do=%h sel=%b want 1 0 00 0 0 0 0 00 00 0",
                     req_ready, rsp_valid, rsp_dat, rsp_status, wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o, wb_sel);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({req_ready, wb_cyc} !== 2'b10)
            $display("FAIL reset_release got rdy/cyc=%b%b want 10", req_ready, wb_cyc);
        else n_pass++;
        $display("txn reset done");
    endtask

    task automatic test_read_zero_wait();
        issue(8'h12, 1'b0, 8'h00);
        n_checks++;
        if ({wb_cyc, wb_stb, wb_we, wb_adr, rsp_valid, req_ready} !== {1'b1, 1'b1, 1'b0, 8'h12, 1'b0, 1'b0})
            $display("FAIL read_bus got cyc=%b stb=%b we=%b adr=%h vld=%b rdy=%b want 1 1 0 12 0 0",
                     wb_cyc, wb_stb, wb_we, wb_adr, rsp_valid, req_ready);
        else n_pass++;
        wb_dat_i = 8'hA5;
        wb_ack   = 1'b1;
        @(negedge clk);
        wb_ack   = 1'b0;
        wb_dat_i = 8'h00;
        n_checks++;
        if ({rsp_valid, rsp_dat, rsp_status, wb_cyc, wb_stb} !== {1'b1, 8'hA5, 2'd0, 1'b0, 1'b0})
            $display("FAIL read_rsp got vld=%b dat=%h st=%0d cyc=%b stb=%b want 1 a5 0 0 0",
                     rsp_valid, rsp_dat, rsp_status, wb_cyc, wb_stb);
        else n_pass++;
        $display("txn read adr=12 dat=%h status=%0d", rsp_dat, rsp_status);
        consume();
        n_checks++;
        if ({rsp_valid, req_ready} !== 2'b01)
            $display("FAIL read_done got vld/rdy=%b%b want 01", rsp_valid, req_ready);
        else n_pass++;
    endtask

    task automatic test_write_waits();
        int cyc_cnt = 0;
        issue(8'h40, 1'b1, 8'h3C);
        n_checks++;
        if ({wb_we, wb_dat_o, wb_adr, wb_sel} !== {1'b1, 8'h3C, 8'h40, 1'b1})
            $display("FAIL write_bus got we=%b do=%h adr=%h sel=%b want 1 3c 40 1", wb_we, wb_dat_o, wb_adr, wb_sel);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            if (wb_cyc && wb_stb) cyc_cnt++;
            if (i == 3) wb_ack = 1'b1;
            @(negedge clk);
        end
        wb_ack = 1'b0;
        n_checks++;
        if (cyc_cnt !== 4)
            $display("FAIL write_cyc_len got %0d want 4", cyc_cnt);
        else n_pass++;
        n_checks++;
        if ({rsp_valid, rsp_dat, rsp_status, wb_cyc, wb_we} !== {1'b1, 8'h00, 2'd0, 1'b0, 1'b0})
            $display("FAIL write_rsp got vld=%b dat=%h st=%0d cyc=%b we=%b want 1 00 0 0 0",
                     rsp_valid, rsp_dat, rsp_status, wb_cyc, wb_we);
        else n_pass++;
        $display("txn write adr=40 dat=3c waits=3 status=%0d", rsp_status);
        consume();
    endtask

    task automatic test_retry_then_ack();
        logic [6:0] pattern = '0;
        int attempts = 0;
        issue(8'h55, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            pattern = {pattern[5:0], wb_cyc};
            if (wb_cyc) begin
                attempts++;
                if (attempts <= 2) wb_rty = 1'b1;
                else begin
                    wb_ack   = 1'b1;
                    wb_dat_i = 8'h5A;
                end
            end
            @(negedge clk);
            wb_rty = 1'b0;
            wb_ack = 1'b0;
        end
        wb_dat_i = 8'h00;
        n_checks++;
        if (pattern[4:0] !== 5'b10101)
            $display("FAIL retry_gaps got cyc pattern %b want 10101", pattern[4:0]);
        else n_pass++;
        n_checks++;
        if ({rsp_valid, rsp_status, rsp_dat} !== {1'b1, 2'd0, 8'h5A})
            $display("FAIL retry_rsp got vld=%b st=%0d dat=%h want 1 0 5a", rsp_valid, rsp_status, rsp_dat);
        else n_pass++;
        $display("txn read adr=55 retries=2 dat=%h status=%0d", rsp_dat, rsp_status);
        consume();
    endtask

    task automatic test_retry_exhausted();
        logic [6:0] pattern = '0;
        issue(8'h66, 1'b0, 8'h00);
        wb_rty   = 1'b1;
        wb_dat_i = 8'hEE;
        for (int i = 0; i < 7; i++) begin
            pattern = {pattern[5:0], wb_cyc};
            @(negedge clk);
        end
        n_checks++;
        if (pattern !== 7'b1010101)
            $display("FAIL exhaust_attempts got cyc pattern %b want 1010101", pattern);
        else n_pass++;
        n_checks++;
        if ({rsp_valid, rsp_status, rsp_dat, wb_cyc} !== {1'b1, 2'd2, 8'h00, 1'b0})
            $display("FAIL exhaust_rsp got vld=%b st=%0d dat=%h cyc=%b want 1 2 00 0",
                     rsp_valid, rsp_status, rsp_dat, wb_cyc);
        else n_pass++;
        $display("txn read adr=66 rty x4 status=%0d", rsp_status);
        consume();
        wb_rty   = 1'b0;
        wb_dat_i = 8'h00;
    endtask

    task automatic test_err_priority_stall();
        int bad = 0;
        issue(8'h77, 1'b0, 8'h00);
        wb_err    = 1'b1;
        wb_ack    = 1'b1;
        wb_dat_i  = 8'hFF;
        rsp_ready = 1'b1;  // early ready must not pre-consume the response
        @(negedge clk);
        wb_err    = 1'b0;
        wb_ack    = 1'b0;
        wb_dat_i  = 8'h00;
        rsp_ready = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_status, rsp_dat} !== {1'b1, 2'd1, 8'h00})
            $display("FAIL err_rsp got vld=%b st=%0d dat=%h want 1 1 00", rsp_valid, rsp_status, rsp_dat);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!(rsp_valid === 1'b1 && rsp_status === 2'd1 && rsp_dat === 8'h00 && req_ready === 1'b0))
                bad++;
        end
        n_checks++;
        if (bad !== 0)
            $display("FAIL stall_stable got %0d unstable cycles want 0", bad);
        else n_pass++;
        $display("txn read adr=77 err+ack status=%0d", rsp_status);
        consume();
        n_checks++;
        if ({rsp_valid, req_ready} !== 2'b01)
            $display("FAIL stall_release got vld/rdy=%b%b want 01", rsp_valid, req_ready);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        issue(8'h44, 1'b0, 8'h00);
        wb_ack   = 1'b1;
        wb_dat_i = 8'h4D;
        @(negedge clk);
        wb_ack   = 1'b0;
        wb_dat_i = 8'h00;
        n_checks++;
        if ({rsp_valid, rsp_dat} !== {1'b1, 8'h4D})
            $display("FAIL b2b_first got vld=%b dat=%h want 1 4d", rsp_valid, rsp_dat);
        else n_pass++;
        $display("txn read adr=44 dat=%h status=%0d", rsp_dat, rsp_status);
        rsp_ready = 1'b1;
        req_adr   = 8'h45;
        req_we    = 1'b0;
        req_valid = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_checks++;
        if ({req_ready, wb_cyc, rsp_valid} !== 3'b100)
            $display("FAIL b2b_gap got rdy=%b cyc=%b vld=%b want 1 0 0", req_ready, wb_cyc, rsp_valid);
        else n_pass++;
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++;
        if ({wb_cyc, wb_adr} !== {1'b1, 8'h45})
            $display("FAIL b2b_second_bus got cyc=%b adr=%h want 1 45", wb_cyc, wb_adr);
        else n_pass++;
        wb_ack   = 1'b1;
        wb_dat_i = 8'h4E;
        @(negedge clk);
        wb_ack   = 1'b0;
        wb_dat_i = 8'h00;
        n_checks++;
        if ({rsp_valid, rsp_dat, rsp_status} !== {1'b1, 8'h4E, 2'd0})
            $display("FAIL b2b_second_rsp got vld=%b dat=%h st=%0d want 1 4e 0", rsp_valid, rsp_dat, rsp_status);
        else n_pass++;
        $display("txn read adr=45 dat=%h status=%0d", rsp_dat, rsp_status);
        consume();
    endtask

`ifdef WB_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int cyc_cnt = 0;
        issue(8'h21, 1'b0, 8'h00);
        for (int i = 0; i < 20 && wb_cyc; i++) begin
            cyc_cnt++;
            @(negedge clk);
        end
        n_checks++;
        if (cyc_cnt !== 8)
            $display("FAIL timeout_len got %0d cyc cycles want 8", cyc_cnt);
        else n_pass++;
        n_checks++;
        if ({rsp_valid, rsp_status, rsp_dat} !== {1'b1, 2'd3, 8'h00})
            $display("FAIL timeout_rsp got vld=%b st=%0d dat=%h want 1 3 00", rsp_valid, rsp_status, rsp_dat);
        else n_pass++;
        $display("txn read adr=21 silent slave status=%0d", rsp_status);
        consume();
    endtask
`else
    task automatic test_timeout();
        int bad = 0;
        issue(8'h21, 1'b0, 8'h00);
        for (int i = 0; i < 120; i++) begin
            if (wb_cyc !== 1'b1 || rsp_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad !== 0)
            $display("FAIL no_timeout_hold got %0d bad cycles want 0", bad);
        else n_pass++;
        wb_ack   = 1'b1;
        wb_dat_i = 8'h6E;
        @(negedge clk);
        wb_ack   = 1'b0;
        wb_dat_i = 8'h00;
        n_checks++;
        if ({rsp_valid, rsp_status, rsp_dat} !== {1'b1, 2'd0, 8'h6E})
            $display("FAIL no_timeout_rsp got vld=%b st=%0d dat=%h want 1 0 6e", rsp_valid, rsp_status, rsp_dat);
        else n_pass++;
        $display("txn read adr=21 late ack after 120 cycles status=%0d", rsp_status);
        consume();
    endtask
`endif

    task automatic test_reset_mid();
        int bad = 0;
        issue(8'h2A, 1'b1, 8'h11);
        n_checks++;
        if (wb_cyc !== 1'b1)
            $display("FAIL midrst_pre got cyc=%b want 1", wb_cyc);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({wb_cyc, wb_stb, wb_we, rsp_valid, req_ready, wb_adr, wb_dat_o} !== {5'b00001, 8'h00, 8'h00})
            $display("FAIL midrst_state got cyc=%b stb=%b we=%b vld=%b rdy=%b adr=%h do=%h want 0 0 0 0 1 00 00",
                     wb_cyc, wb_stb, wb_we, rsp_valid, req_ready, wb_adr, wb_dat_o);
        else n_pass++;
        rst    = 1'b0;
        wb_ack = 1'b1;  // stray ack outside CYCLE must be ignored
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || wb_cyc !== 1'b0) bad++;
        end
        wb_ack = 1'b0;
        n_checks++;
        if (bad !== 0)
            $display("FAIL midrst_no_rsp got %0d bad cycles want 0", bad);
        else n_pass++;
        $display("txn write adr=2a dropped by reset");
        issue(8'h33, 1'b0, 8'h00);
        wb_ack   = 1'b1;
        wb_dat_i = 8'hC3;
        @(negedge clk);
        wb_ack   = 1'b0;
        wb_dat_i = 8'h00;
        n_checks++;
        if ({rsp_valid, rsp_status, rsp_dat} !== {1'b1, 2'd0, 8'hC3})
            $display("FAIL midrst_after got vld=%b st=%0d dat=%h want 1 0 c3", rsp_valid, rsp_status, rsp_dat);
        else n_pass++;
        $display("txn read adr=33 dat=%h status=%0d", rsp_dat, rsp_status);
        consume();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_adr   = '0;
        req_we    = 1'b0;
        req_dat   = '0;
        req_sel   = '0;
        rsp_ready = 1'b0;
        wb_dat_i  = '0;
        wb_ack    = 1'b0;
        wb_err    = 1'b0;
        wb_rty    = 1'b0;

        test_reset();
        test_read_zero_wait();
        test_write_waits();
        test_retry_then_ack();
        test_retry_exhausted();
        test_err_priority_stall();
        test_back_to_back();
        test_timeout();
        test_reset_mid();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL global_timeout got no completion want finish before 100000");
        $fatal(1, "simulation time bound reached");
    end

endmodule
